// File: rtl/door_unlock_pkg.sv
// door_unlock_pkg: shared state encoding and code constants for the serial door lock.
package door_unlock_pkg;
   typedef enum logic [2:0] {S0, S1, S2, S3, UNLOCKED} door_state_t;
   localparam logic [3:0] CODE = 4'b0010;
   localparam int CODE_LEN = 4;
endpackage

// File: rtl/door_unlock_fsm.sv
// door_unlock_fsm: Moore detector for the serial code 0010 (MSB first); holds unlock until a 1 arrives.
module door_unlock_fsm
   import door_unlock_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic code_in,
   output logic roll_no_02
);
   door_state_t state, next;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= S0;
      else state <= next;
   // S2 keeps itself on 0 so any run of leading zeros still counts as the 00 prefix
   always_comb begin
      next = S0;
      case (state)
         S0:       next = code_in ? S0 : S1;
         S1:       next = code_in ? S0 : S2;
         S2:       next = code_in ? S3 : S2;
         S3:       next = code_in ? S0 : UNLOCKED;
         UNLOCKED: next = code_in ? S0 : UNLOCKED;
         default:  next = S0;
      endcase
   end
   assign roll_no_02 = (state == UNLOCKED);
endmodule

// File: tb/tb_door_unlock_fsm.sv
// tb_door_unlock_fsm: directed vectors for the serial door lock with hand-computed outputs.
module tb_door_unlock_fsm;
   import door_unlock_pkg::*;
   logic clk, reset, code_in, roll_no_02;
   int tests, fails;

   door_unlock_fsm dut (.clk(clk), .reset(reset), .code_in(code_in), .roll_no_02(roll_no_02));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // bits and exps are read MSB first over n edges; output checked 1 time unit after each edge
   task automatic run(input string tag, input int n, input logic [7:0] bits, input logic [7:0] exps);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk) code_in = bits[i];
         @(posedge clk);
         #1 check($sformatf("%s[%0d]", tag, n - 1 - i), {2'b00, roll_no_02}, {2'b00, exps[i]});
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      code_in = 1'b0;
      #3 reset = 1'b0;
      #1 check("reset_async", {2'b00, roll_no_02}, 3'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1 check("reset_hold", {2'b00, roll_no_02}, 3'd0);
      end
      check("reset_state", 3'(dut.state), 3'(S0));
      @(negedge clk) reset = 1'b1;
      run("wrong", 4, 8'b1010, 8'b0000);
      check("wrong_state", 3'(dut.state), 3'(S1));
      run("history", 3, 8'b010, 8'b001);
      run("hold", 5, 8'b00000, 8'b11111);
      run("relock", 1, 8'b1, 8'b0);
      run("after_relock", 1, 8'b0, 8'b0);
      check("after_relock_state", 3'(dut.state), 3'(S1));
      run("lead_zeros", 6, 8'b000010, 8'b000001);
      run("relock2", 1, 8'b1, 8'b0);
      run("near_miss", 4, 8'b0011, 8'b0000);
      check("near_miss_state", 3'(dut.state), 3'(S0));
      run("from_s0", 3, 8'b010, 8'b000);
      run("unlock_again", 4, 8'b0010, 8'b0001);
      #2 reset = 1'b0;
      #1 check("reset_unlocked", {2'b00, roll_no_02}, 3'd0);
      check("reset_unlocked_state", 3'(dut.state), 3'(S0));
      @(negedge clk) reset = 1'b1;
      run("no_relock", 1, 8'b0, 8'b0);
      run("fresh", 3, 8'b010, 8'b001);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
